// File: rtl/gameplay_input_ctrl.sv
// Input conditioning for gameplay: sync + debounce of buttons, new_game pulse, hit gating, pan, frame strobe.
// Optional CHARGE_TIMEOUT_EN macro adds a frame-based limit on how long charging_hit may stay high.
module gameplay_input_ctrl #(
    parameter int DEBOUNCE_CYCLES       = 1_000_000,
    parameter int NEW_GAME_CYCLES       = 4,
    parameter int VSYNC_ACTIVE_HIGH     = 0,
    parameter int CHARGE_TIMEOUT_FRAMES = 600
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        btn_hit_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_new_game_in,
    input  logic        vsync_in,
    input  logic [2:0]  state_in,
    output logic        new_game,
    output logic        charging_hit,
    output logic        camera_pan_left,
    output logic        camera_pan_right,
    output logic        new_frame,
    output logic [15:0] frame_count
);

    localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int NG_W = $clog2(NEW_GAME_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NG_W-1:0] NG_LAST = NG_W'(NEW_GAME_CYCLES - 1);

    // Button lanes: 0 hit, 1 left, 2 right, 3 new game
    logic [3:0]    raw_btn;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [3:0]    db;
    logic [CW-1:0] db_cnt [4];

    assign raw_btn = {btn_new_game_in, btn_right_in, btn_left_in, btn_hit_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_a <= '0;
            sync_b <= '0;
            db     <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_a <= raw_btn;
            sync_b <= sync_a;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db[i]     <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic            db_new_game_q;
    logic [NG_W-1:0] ng_cnt;
    logic            armed;
    logic            vsync_q;
    logic            vsync_q2;
    logic            frame_edge;
    logic            state_ok;
    logic            hit_timeout;

    assign state_ok   = (state_in == 3'd0) || (state_in == 3'd1);
    assign frame_edge = (VSYNC_ACTIVE_HIGH != 0) ? (vsync_q & ~vsync_q2) : (~vsync_q & vsync_q2);

`ifdef CHARGE_TIMEOUT_EN
    logic [15:0] chg_cnt;

    // Timeout fires on the strobe that brings the count up to the limit
    assign hit_timeout = charging_hit & new_frame & (chg_cnt == 16'(CHARGE_TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            chg_cnt <= '0;
        end else if (!charging_hit) begin
            chg_cnt <= '0;
        end else if (new_frame) begin
            chg_cnt <= chg_cnt + 16'd1;
        end
    end
`else
    // Always false; references the limit so the parameter stays part of the interface
    assign hit_timeout = (CHARGE_TIMEOUT_FRAMES < 0);
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            new_game         <= 1'b1;
            ng_cnt           <= NG_LAST;
            db_new_game_q    <= 1'b0;
            armed            <= 1'b0;
            charging_hit     <= 1'b0;
            camera_pan_left  <= 1'b0;
            camera_pan_right <= 1'b0;
            vsync_q          <= 1'b0;
            vsync_q2         <= 1'b0;
            new_frame        <= 1'b0;
            frame_count      <= '0;
        end else begin
            db_new_game_q <= db[3];
            if (db[3] && !db_new_game_q) begin
                new_game <= 1'b1;
                ng_cnt   <= NG_LAST;
            end else if (new_game) begin
                if (ng_cnt == '0) new_game <= 1'b0;
                else              ng_cnt   <= ng_cnt - 1'b1;
            end

            // A press held across a shot must be released before it can arm again
            if (new_game || !state_ok || hit_timeout) armed <= 1'b0;
            else if (!db[0] && state_in == 3'd0)      armed <= 1'b1;

            charging_hit     <= db[0] & armed & state_ok & ~hit_timeout;
            camera_pan_left  <= db[1] & ~db[2] & ~new_game;
            camera_pan_right <= db[2] & ~db[1] & ~new_game;

            vsync_q   <= vsync_in;
            vsync_q2  <= vsync_q;
            new_frame <= frame_edge;

            if (new_game)       frame_count <= '0;
            else if (new_frame) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gameplay_input_ctrl.sv
// Directed bench for gameplay_input_ctrl with DEBOUNCE_CYCLES=8, NEW_GAME_CYCLES=4, active-low vsync.
module tb_gameplay_input_ctrl;

    localparam int D   = 8;
    localparam int LAT = D + 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        btn_hit_in, btn_left_in, btn_right_in, btn_new_game_in;
    logic        vsync_in;
    logic [2:0]  state_in;
    logic        new_game, charging_hit, camera_pan_left, camera_pan_right, new_frame;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    gameplay_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .NEW_GAME_CYCLES(4),
        .VSYNC_ACTIVE_HIGH(0),
        .CHARGE_TIMEOUT_FRAMES(3)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .btn_hit_in(btn_hit_in),
        .btn_left_in(btn_left_in),
        .btn_right_in(btn_right_in),
        .btn_new_game_in(btn_new_game_in),
        .vsync_in(vsync_in),
        .state_in(state_in),
        .new_game(new_game),
        .charging_hit(charging_hit),
        .camera_pan_left(camera_pan_left),
        .camera_pan_right(camera_pan_right),
        .new_frame(new_frame),
        .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input logic hit, input logic left, input logic right,
                                 input logic ng, input logic [2:0] st);
        btn_hit_in      = hit;
        btn_left_in     = left;
        btn_right_in    = right;
        btn_new_game_in = ng;
        state_in        = st;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        rst_n_in = 1'b0;
        vsync_in = 1'b1;
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(3);
        checkOutput("rst_new_game", 16'(new_game), 16'd1);
        checkOutput("rst_frame_count", frame_count, 16'd0);
        checkOutput("rst_others", 16'({charging_hit, camera_pan_left, camera_pan_right, new_frame}), 16'd0);

        rst_n_in = 1'b1;
        step(3);
        checkOutput("ng_after_rel_3", 16'(new_game), 16'd1);
        step(1);
        checkOutput("ng_after_rel_4", 16'(new_game), 16'd0);
        checkOutput("no_frame_at_rel", 16'(new_frame), 16'd0);
        step(5);

        // Short glitch must not reach the debounced level
        applyStimulus(1, 0, 0, 0, 3'd0);
        step(5);
        applyStimulus(0, 0, 0, 0, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen |= charging_hit;
        end
        checkOutput("hit_glitch", 16'(seen), 16'd0);

        applyStimulus(1, 0, 0, 0, 3'd0);
        step(LAT - 1);
        checkOutput("hit_lat_minus1", 16'(charging_hit), 16'd0);
        step(1);
        checkOutput("hit_lat", 16'(charging_hit), 16'd1);
        step(9);

        applyStimulus(1, 0, 0, 0, 3'd1);
        step(3);
        checkOutput("hit_charging", 16'(charging_hit), 16'd1);
        applyStimulus(1, 0, 0, 0, 3'd2);
        step(2);
        checkOutput("hit_on_hit", 16'(charging_hit), 16'd0);
        applyStimulus(1, 0, 0, 0, 3'd3);
        step(2);
        applyStimulus(1, 0, 0, 0, 3'd0);
        step(5);
        checkOutput("hit_held_resting", 16'(charging_hit), 16'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);
        applyStimulus(1, 0, 0, 0, 3'd0);
        step(LAT - 1);
        checkOutput("repress_minus1", 16'(charging_hit), 16'd0);
        step(1);
        checkOutput("repress", 16'(charging_hit), 16'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);
        applyStimulus(1, 0, 0, 0, 3'd5);
        step(15);
        checkOutput("hit_in_hole", 16'(charging_hit), 16'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);

        // Pan: both held cancel out
        applyStimulus(0, 1, 1, 0, 3'd3);
        step(15);
        checkOutput("pan_both", 16'({camera_pan_left, camera_pan_right}), 16'd0);
        applyStimulus(0, 1, 0, 0, 3'd3);
        step(LAT - 1);
        checkOutput("pan_left_minus1", 16'(camera_pan_left), 16'd0);
        step(1);
        checkOutput("pan_left", 16'({camera_pan_left, camera_pan_right}), 16'b10);
        applyStimulus(0, 0, 1, 0, 3'd3);
        step(15);
        checkOutput("pan_right", 16'({camera_pan_left, camera_pan_right}), 16'b01);
        applyStimulus(0, 1, 0, 0, 3'd0);
        step(15);

        // New-game button with left held: pulse length, pan suppression, no retrigger
        applyStimulus(0, 1, 0, 1, 3'd0);
        step(LAT);
        checkOutput("ng_btn_start", 16'(new_game), 16'd1);
        step(3);
        checkOutput("ng_btn_last", 16'(new_game), 16'd1);
        checkOutput("pan_suppressed", 16'(camera_pan_left), 16'd0);
        step(1);
        checkOutput("ng_btn_end", 16'(new_game), 16'd0);
        step(15);
        checkOutput("ng_no_retrigger", 16'(new_game), 16'd0);
        checkOutput("pan_after_ng", 16'(camera_pan_left), 16'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);

        // Frame strobe on falling vsync, none on rising
        vsync_in = 1'b0;
        step(1);
        checkOutput("nf_lat1", 16'(new_frame), 16'd0);
        step(1);
        checkOutput("nf_lat2", 16'(new_frame), 16'd1);
        step(1);
        checkOutput("nf_one_cycle", 16'(new_frame), 16'd0);
        checkOutput("fc_first", frame_count, 16'd1);
        vsync_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            seen |= new_frame;
        end
        checkOutput("nf_rising_none", 16'(seen), 16'd0);
        checkOutput("fc_hold", frame_count, 16'd1);

        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        step(1);
        vsync_in = 1'b0;
        step(3);
        checkOutput("fc_wrap", frame_count, 16'd0);
        vsync_in = 1'b1;
        step(3);
        vsync_in = 1'b0;
        step(3);
        checkOutput("fc_after_wrap", frame_count, 16'd1);
        vsync_in = 1'b1;
        step(3);

        // new_game and new_frame in the same cycle: clear wins
        applyStimulus(0, 0, 0, 1, 3'd0);
        step(LAT - 2);
        vsync_in = 1'b0;
        step(2);
        checkOutput("coinc_ng", 16'(new_game), 16'd1);
        checkOutput("coinc_nf", 16'(new_frame), 16'd1);
        step(1);
        checkOutput("coinc_fc", frame_count, 16'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        vsync_in = 1'b1;
        step(20);

`ifdef CHARGE_TIMEOUT_EN
        applyStimulus(1, 0, 0, 0, 3'd0);
        step(LAT);
        checkOutput("to_charge", 16'(charging_hit), 16'd1);
        applyStimulus(1, 0, 0, 0, 3'd1);
        for (int f = 0; f < 2; f++) begin
            vsync_in = 1'b0;
            step(2);
            vsync_in = 1'b1;
            step(2);
        end
        checkOutput("to_two_frames", 16'(charging_hit), 16'd1);
        vsync_in = 1'b0;
        step(2);
        checkOutput("to_third_strobe", 16'(charging_hit), 16'd1);
        step(1);
        checkOutput("to_fall", 16'(charging_hit), 16'd0);
        vsync_in = 1'b1;
        step(10);
        checkOutput("to_stays_low", 16'(charging_hit), 16'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);
        applyStimulus(1, 0, 0, 0, 3'd0);
        step(LAT);
        checkOutput("to_repress", 16'(charging_hit), 16'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        step(15);
`endif

        // Async reset mid-pulse returns everything to reset values at once
        applyStimulus(1, 1, 0, 1, 3'd0);
        step(LAT + 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_rst_ng", 16'(new_game), 16'd1);
        checkOutput("async_rst_outs", 16'({charging_hit, camera_pan_left, camera_pan_right, new_frame}), 16'd0);
        checkOutput("async_rst_fc", frame_count, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
